// File: rtl/fifo_pkg.sv
// Shared sizing defaults for sync_fifo and its read-side stream adapter.
// Includes a constant log2 helper for pointer widths.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 8;
  localparam int FIFO_PTR_DEF   = 4;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int OBUF_DEPTH_DEF = 4;

  // Smallest r with (1 << r) >= n.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_obuf.sv
// Prefetch ring storage: OBUF_DEPTH x FIFO_WIDTH registers.
// One write port, one asynchronous read port addressed by the head pointer.
module sync_fifo_obuf
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int OBUF_DEPTH = OBUF_DEPTH_DEF,
  parameter int OBUF_PTR   = clog2(OBUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] wr_data,
  input  logic [OBUF_PTR-1:0]   wr_ptr,
  input  logic [OBUF_PTR-1:0]   rd_ptr,
  output logic [FIFO_WIDTH-1:0] rd_data
);

  logic [FIFO_WIDTH-1:0] mem_q [OBUF_DEPTH];
  logic [FIFO_WIDTH-1:0] mem_d [OBUF_DEPTH];

  // Write the captured word into the tail slot.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr] = wr_data;
  end

  // Storage registers; cleared so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OBUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/sync_fifo_rd_stream.sv
// Turns the sync_fifo 1-cycle-latency rden/rddata pull port into a
// first-word-fall-through valid/ready stream via a small prefetch ring.
module sync_fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int OBUF_DEPTH = OBUF_DEPTH_DEF,
  parameter int OBUF_PTR   = clog2(OBUF_DEPTH)
) (
  input  logic                  fifo_clk,
  input  logic                  fifo_rst,
  output logic                  fifo_rden,
  input  logic [FIFO_WIDTH-1:0] fifo_rddata,
  input  logic                  fifo_empty,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FIFO_WIDTH-1:0] out_data,
  output logic [OBUF_PTR:0]     out_count
);

  localparam int OCC_W = OBUF_PTR + 2;

  logic [OBUF_PTR:0]   cnt_q, cnt_d;
  logic                inflight_q, inflight_d;
  logic [OBUF_PTR-1:0] rd_ptr_q, rd_ptr_d;
  logic [OBUF_PTR-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]    occ;
  logic                capture;
  logic                pop;

  // Issue a read only if a slot is free counting the word already in flight;
  // out_ready is deliberately not in this path.
  always_comb begin
    occ       = OCC_W'(cnt_q) + OCC_W'(inflight_q);
    fifo_rden = !fifo_rst && !fifo_empty && !flush &&
                (occ < OCC_W'(OBUF_DEPTH));
  end

  assign out_valid = (cnt_q != '0);
  assign out_count = cnt_q;
  assign capture   = inflight_q && !flush;
  assign pop       = out_valid && out_ready;

  // Occupancy and pointer bookkeeping; flush drops buffered and in-flight words.
  always_comb begin
    inflight_d = fifo_rden;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (flush) begin
      inflight_d = 1'b0;
      cnt_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (capture) wr_ptr_d = wr_ptr_q + OBUF_PTR'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + OBUF_PTR'(1);
      if (capture && !pop) cnt_d = cnt_q + (OBUF_PTR+1)'(1);
      if (!capture && pop) cnt_d = cnt_q - (OBUF_PTR+1)'(1);
    end
  end

  // State registers.
  always_ff @(posedge fifo_clk or posedge fifo_rst) begin
    if (fifo_rst) begin
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // A capture into a full ring without a pop would lose a word.
  a_no_overflow: assert property (
    @(posedge fifo_clk) disable iff (fifo_rst)
    !(capture && !pop && (cnt_q == (OBUF_PTR+1)'(OBUF_DEPTH)))
  );

  sync_fifo_obuf #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .OBUF_DEPTH (OBUF_DEPTH),
    .OBUF_PTR   (OBUF_PTR)
  ) u_obuf (
    .clk     (fifo_clk),
    .rst     (fifo_rst),
    .wr_en   (capture),
    .wr_data (fifo_rddata),
    .wr_ptr  (wr_ptr_q),
    .rd_ptr  (rd_ptr_q),
    .rd_data (out_data)
  );

endmodule

// File: tb/tb_sync_fifo_rd_stream.sv
// Bench for sync_fifo_rd_stream: behavioural 16-deep upstream FIFO,
// scoreboard queue filled on upstream writes, monitor on the stream side.
module tb_sync_fifo_rd_stream;

  logic       clk;
  logic       rst;
  logic       fifo_rden;
  logic [7:0] fifo_rddata;
  logic       fifo_empty;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_count;

  logic       wr_en;
  logic [7:0] wr_data;

  logic [7:0] umem [16];
  logic [3:0] urp;
  logic [3:0] uwp;
  int         ucnt;

  logic [7:0] exp_q [$];
  int         rd_cyc_q [$];
  int         cyc;
  int         seq;
  int         checks;
  int         failures;
  bit         lat_en;

  sync_fifo_rd_stream #(
    .FIFO_WIDTH (8),
    .OBUF_DEPTH (4),
    .OBUF_PTR   (2)
  ) dut (
    .fifo_clk    (clk),
    .fifo_rst    (rst),
    .fifo_rden   (fifo_rden),
    .fifo_rddata (fifo_rddata),
    .fifo_empty  (fifo_empty),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_count   (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty = (ucnt == 0);

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream sync_fifo model: 16 deep, rddata valid the cycle after rden.
  always @(posedge clk) begin
    if (fifo_rden) begin
      fifo_rddata <= umem[urp];
      urp         <= urp + 4'd1;
    end
    if (wr_en && ucnt < 16) begin
      umem[uwp] <= wr_data;
      uwp       <= uwp + 4'd1;
      exp_q.push_back(wr_data);
    end
    ucnt <= ucnt + ((wr_en && ucnt < 16) ? 1 : 0) - (fifo_rden ? 1 : 0);
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  // Stream monitor: pops the scoreboard on every accepted word.
  initial begin
    bit         stall_prev;
    bit         flush_prev;
    logic [7:0] data_prev;
    stall_prev = 1'b0;
    flush_prev = 1'b0;
    data_prev  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
        flush_prev = 1'b0;
      end else begin
        if (fifo_rden) rd_cyc_q.push_back(cyc);
        if (fifo_empty) check("rden_while_empty", int'(fifo_rden), 0);
        if (out_count > 3'd4) check("out_count_max", int'(out_count), 4);
        if (stall_prev && !flush_prev) begin
          check("stall_valid", int'(out_valid), 1);
          check("stall_data", int'(out_data), int'(data_prev));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", int'(out_data), -1);
          end else begin
            check("data_order", int'(out_data), int'(exp_q.pop_front()));
          end
          if (lat_en) begin
            if (rd_cyc_q.size() == 0) check("lat_no_read", cyc, -1);
            else check("read_to_out_lat", cyc - rd_cyc_q.pop_front(), 2);
          end
        end
        stall_prev = out_valid && !out_ready;
        flush_prev = flush;
        data_prev  = out_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word();
    wr_en   = 1'b1;
    wr_data = 8'(seq);
    seq++;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ucnt != 0) && n < 300) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int first_rd;
    int first_v;
    int last_v;
    int nd;
    int pulses;
    int gap;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    seq      = 8'h10;
    lat_en   = 1'b0;
    urp      = '0;
    uwp      = '0;
    ucnt     = 0;
    fifo_rddata = '0;
    wr_en     = 1'b0;
    wr_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;

    // 1: reset held with words waiting upstream
    repeat (5) wr_word();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_rden", int'(fifo_rden), 0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_count", int'(out_count), 0);
    end
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    drain("t1_drain");

    // 2: 16 preloaded words stream at one per cycle
    flush = 1'b1;
    repeat (16) wr_word();
    flush    = 1'b0;
    first_rd = -1;
    first_v  = -1;
    last_v   = -1;
    nd       = 0;
    for (int c = 0; c < 60 && nd < 16; c++) begin
      @(negedge clk);
      if (fifo_rden && first_rd < 0) first_rd = cyc;
      if (out_valid && out_ready) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        nd++;
      end
    end
    check("t2_words", nd, 16);
    check("t2_first_lat", first_v - first_rd, 2);
    check("t2_burst_len", last_v - first_v, 15);
    tick();
    drain("t2_drain");

    // 3: consumer stalled, prefetch fills to four
    out_ready = 1'b0;
    flush     = 1'b1;
    repeat (16) wr_word();
    flush  = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (fifo_rden) pulses++;
    end
    check("t3_rden_pulses", pulses, 4);
    check("t3_out_count", int'(out_count), 4);
    check("t3_upstream_left", ucnt, 12);
    tick();
    out_ready = 1'b1;
    drain("t3_drain");

    // 4: spaced writes, per-word read-to-output latency
    rd_cyc_q.delete();
    lat_en = 1'b1;
    for (int rwd = 0; rwd <= 4; rwd++) begin
      for (int k = 0; k < 6; k++) begin
        wr_word();
        repeat (rwd) tick();
      end
    end
    drain("t4_drain");
    lat_en = 1'b0;

    // 5: flush with two buffered words and one in flight
    out_ready = 1'b0;
    flush     = 1'b1;
    repeat (6) wr_word();
    flush = 1'b0;
    repeat (3) tick();
    flush = 1'b1;
    @(negedge clk);
    check("t5_pre_count", int'(out_count), 2);
    check("t5_flush_rden", int'(fifo_rden), 0);
    repeat (3) void'(exp_q.pop_front());
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("t5_post_valid", int'(out_valid), 0);
    check("t5_post_count", int'(out_count), 0);
    check("t5_upstream_left", ucnt, 3);
    tick();
    out_ready = 1'b1;
    drain("t5_drain");

    // 6: random ready and write spacing
    gap = 0;
    for (int c = 0; c < 10000; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      wr_en     = 1'b0;
      if (gap == 0) begin
        if (ucnt < 16) begin
          wr_en   = 1'b1;
          wr_data = 8'(seq);
          seq++;
        end
        gap = $urandom_range(0, 4);
      end else begin
        gap--;
      end
      tick();
    end
    wr_en     = 1'b0;
    out_ready = 1'b1;
    drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
